// File: rtl/request_inserter.sv
// request_inserter: takes one floor request at a time, scans the floor-request
// queue RAM through its asynchronous secondary read port, and issues a single
// insert-at-index (fit) or append (weT) pulse at the sweep-ordered position.
// Duplicates, floor 0 and a full queue are dropped, each with its own pulse.
//
// Handshake: a request is taken on a rising clk edge where req_valid and
// req_ready are both high. req_ready is high only while IDLE, and req_floor,
// current_floor and going_up are sampled on that same edge.
module request_inserter #(
  parameter int DEPTH = 16,
  parameter int FW    = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     req_valid,
  input  logic [FW-1:0]            req_floor,
  output logic                     req_ready,
  input  logic [FW-1:0]            current_floor,
  input  logic                     going_up,
  input  logic                     queue_shift,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic [FW-1:0]            rd_data,
  output logic [$clog2(DEPTH)-1:0] ins_addr,
  output logic [FW-1:0]            ins_data,
  output logic                     ins_fit,
  output logic                     ins_append,
  output logic                     dup_drop,
  output logic                     full_drop,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [FW:0]   WRAP = {1'b0, {FW{1'b1}}};

  typedef enum logic [1:0] {IDLE, CHKF, SCAN, ISSUE} state_t;

  state_t        state;
  logic [FW-1:0] floor_q;
  logic [FW-1:0] cur_q;
  logic          up_q;
  logic [AW-1:0] idx;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] ins_addr_q;
  logic [FW-1:0] ins_data_q;
  logic          fit_q;
  logic          app_q;
  logic          dup_q;
  logic          full_q;
  logic          ready_q;
  logic [FW:0]   key_rd;
  logic [FW:0]   key_req;

  // Distance along the current sweep: floors ahead come first in travel
  // order, floors behind the car come after the turnaround (offset by 15).
  function automatic logic [FW:0] sweep_key(input logic [FW-1:0] f,
                                            input logic [FW-1:0] c,
                                            input logic          up);
    logic [FW:0] k;
    if (up) begin
      if (f >= c) k = {1'b0, f} - {1'b0, c};
      else        k = WRAP + ({1'b0, c} - {1'b0, f});
    end else begin
      if (f <= c) k = {1'b0, c} - {1'b0, f};
      else        k = WRAP + ({1'b0, f} - {1'b0, c});
    end
    return k;
  endfunction

  // Sweep keys of the entry under the scan pointer and of the pending request.
  always_comb begin
    key_rd  = sweep_key(rd_data, cur_q, up_q);
    key_req = sweep_key(floor_q, cur_q, up_q);
  end

  // Request FSM: latch, check for room, scan, then issue one registered pulse.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      floor_q    <= '0;
      cur_q      <= '0;
      up_q       <= 1'b0;
      idx        <= '0;
      rd_addr_q  <= '0;
      ins_addr_q <= '0;
      ins_data_q <= '0;
      fit_q      <= 1'b0;
      app_q      <= 1'b0;
      dup_q      <= 1'b0;
      full_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      fit_q  <= 1'b0;
      app_q  <= 1'b0;
      dup_q  <= 1'b0;
      full_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && ready_q) begin
            floor_q <= req_floor;
            cur_q   <= current_floor;
            up_q    <= going_up;
            if (req_floor == '0) begin
              dup_q <= 1'b1;
            end else begin
              state     <= CHKF;
              rd_addr_q <= LAST;
              ready_q   <= 1'b0;
            end
          end
        end
        CHKF: begin
          // A head pop changes every entry; simply look at the last slot again.
          if (queue_shift) begin
            rd_addr_q <= LAST;
          end else if (rd_data != '0) begin
            full_q    <= 1'b1;
            state     <= IDLE;
            ready_q   <= 1'b1;
            rd_addr_q <= '0;
          end else begin
            idx       <= '0;
            rd_addr_q <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (queue_shift) begin
            state     <= CHKF;
            rd_addr_q <= LAST;
          end else if (rd_data == floor_q) begin
            dup_q     <= 1'b1;
            state     <= IDLE;
            ready_q   <= 1'b1;
            rd_addr_q <= '0;
          end else if (rd_data == '0) begin
            app_q      <= 1'b1;
            ins_data_q <= floor_q;
            state      <= ISSUE;
          end else if (key_rd > key_req) begin
            fit_q      <= 1'b1;
            ins_addr_q <= idx;
            ins_data_q <= floor_q;
            state      <= ISSUE;
          end else begin
            idx       <= idx + 1'b1;
            rd_addr_q <= idx + 1'b1;
          end
        end
        ISSUE: begin
          ins_addr_q <= '0;
          ins_data_q <= '0;
          if (queue_shift) begin
            // The pulse was masked this cycle; rescan against the shifted queue.
            state     <= CHKF;
            rd_addr_q <= LAST;
          end else begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // A write must never coincide with a head pop, so the pulses are masked.
  assign ins_fit    = fit_q & ~queue_shift;
  assign ins_append = app_q & ~queue_shift;
  assign dup_drop   = dup_q;
  assign full_drop  = full_q;
  assign rd_addr    = rd_addr_q;
  assign ins_addr   = ins_addr_q;
  assign ins_data   = ins_data_q;
  assign req_ready  = ready_q;
  assign busy       = ~ready_q;

endmodule

// File: tb/tb_request_inserter.sv
// Bench for request_inserter: a behavioural 16x4 queue RAM, a table of
// directed requests with hand-computed outcomes, and hand-written sequences
// for head pops during a scan, a head pop on the issue cycle, and clear.
module tb_request_inserter;

  logic       clk = 1'b0;
  logic       clear;
  logic       req_valid;
  logic [3:0] req_floor;
  logic       req_ready;
  logic [3:0] current_floor;
  logic       going_up;
  logic       queue_shift;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] ins_addr;
  logic [3:0] ins_data;
  logic       ins_fit;
  logic       ins_append;
  logic       dup_drop;
  logic       full_drop;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // clock
  always #5 clk = ~clk;

  request_inserter dut (
    .clk(clk), .clear(clear), .req_valid(req_valid), .req_floor(req_floor),
    .req_ready(req_ready), .current_floor(current_floor), .going_up(going_up),
    .queue_shift(queue_shift), .rd_addr(rd_addr), .rd_data(rd_data),
    .ins_addr(ins_addr), .ins_data(ins_data), .ins_fit(ins_fit),
    .ins_append(ins_append), .dup_drop(dup_drop), .full_drop(full_drop),
    .busy(busy)
  );

  // queue RAM model
  logic [3:0]  ram [16];
  logic        load_en = 1'b0;
  logic [63:0] load_val = '0;
  logic [3:0]  ram_addr;
  int          app_slot;

  assign ram_addr = ins_fit ? ins_addr : rd_addr;
  assign rd_data  = ram[ram_addr];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 16; i++) ram[i] <= load_val[4*i +: 4];
    end else if (queue_shift) begin
      for (int i = 0; i < 15; i++) ram[i] <= ram[i+1];
      ram[15] <= 4'd0;
    end else if (ins_fit) begin
      for (int i = 15; i > 0; i--) if (i > int'(ins_addr)) ram[i] <= ram[i-1];
      ram[ins_addr] <= ins_data;
    end else if (ins_append) begin
      app_slot = -1;
      for (int i = 0; i < 16; i++) if (app_slot < 0 && ram[i] == 4'd0) app_slot = i;
      if (app_slot >= 0) ram[app_slot] <= ins_data;
    end
  end

  function automatic logic [63:0] ram_pack();
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = ram[i];
    return r;
  endfunction

  // scoreboard helpers
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input logic [63:0] exp);
    logic [63:0] act;
    act = ram_pack();
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: queue got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic load_queue(input logic [63:0] v);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Presents one request; the caller resumes just after the accepting edge.
  // Position and direction are scrambled afterwards and must be ignored.
  task automatic send_req(input logic [3:0] f, input logic [3:0] c, input logic up);
    @(negedge clk);
    req_floor     = f;
    current_floor = c;
    going_up      = up;
    req_valid     = 1'b1;
    #1;
    check("ready_before_accept", int'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid     = 1'b0;
    current_floor = ~c;
    going_up      = ~up;
  endtask

  // kind: 0 fit, 1 append, 2 dup, 3 full, 4 none within the cycle budget
  task automatic wait_pulse(output int n, output int kind, output int npulse,
                            output logic [3:0] a, output logic [3:0] d);
    n = 0; kind = 4; npulse = 0; a = '0; d = '0;
    while (kind == 4 && n < 40) begin
      @(negedge clk);
      n++;
      npulse = int'(ins_fit) + int'(ins_append) + int'(dup_drop) + int'(full_drop);
      a = ins_addr;
      d = ins_data;
      if (ins_fit)         kind = 0;
      else if (ins_append) kind = 1;
      else if (dup_drop)   kind = 2;
      else if (full_drop)  kind = 3;
    end
    if (kind == 4) check("pulse_timeout", 0, 1);
  endtask

  typedef struct {
    logic [63:0] q_in;
    logic [3:0]  cur;
    logic        up;
    logic [3:0]  floor;
    int          kind;
    logic [3:0]  addr;
    int          lat;
    logic [63:0] q_out;
  } vec_t;

  vec_t vecs [10];

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1);
  end

  initial begin
    int n, kind, np;
    logic [3:0] a, d;

    vecs[0] = '{64'h73,   4'd2, 1'b1, 4'd5,  0, 4'd1, 4, 64'h753};
    vecs[1] = '{64'h73,   4'd2, 1'b1, 4'd7,  2, 4'd0, 4, 64'h73};
    vecs[2] = '{64'h73,   4'd2, 1'b1, 4'd1,  1, 4'd0, 5, 64'h173};
    vecs[3] = '{64'hC4,   4'd9, 1'b0, 4'd6,  0, 4'd0, 3, 64'hC46};
    vecs[4] = '{64'h8FED_CBA9_8765_4321, 4'd2, 1'b1, 4'd2, 3, 4'd0, 2,
                64'h8FED_CBA9_8765_4321};
    vecs[5] = '{64'h73,   4'd2, 1'b1, 4'd0,  2, 4'd0, 1, 64'h73};
    vecs[6] = '{64'h0,    4'd5, 1'b1, 4'd9,  1, 4'd0, 3, 64'h9};
    vecs[7] = '{64'hC4,   4'd9, 1'b0, 4'd10, 0, 4'd1, 4, 64'hCA4};
    vecs[8] = '{64'h2C8,  4'd5, 1'b1, 4'd10, 0, 4'd1, 4, 64'h2CA8};
    vecs[9] = '{64'h6,    4'd6, 1'b1, 4'd6,  2, 4'd0, 3, 64'h6};

    // reset
    clear = 1'b1; req_valid = 1'b0; req_floor = '0; current_floor = '0;
    going_up = 1'b0; queue_shift = 1'b0;
    load_queue(64'h0);
    #1;
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'(ins_fit) + int'(ins_append) + int'(dup_drop) + int'(full_drop), 0);
    check("rst_ins_addr", int'(ins_addr), 0);
    check("rst_ins_data", int'(ins_data), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    @(negedge clk);
    clear = 1'b0;

    // table-driven requests
    for (int v = 0; v < 10; v++) begin
      load_queue(vecs[v].q_in);
      send_req(vecs[v].floor, vecs[v].cur, vecs[v].up);
      wait_pulse(n, kind, np, a, d);
      check($sformatf("v%0d_kind", v), kind, vecs[v].kind);
      check($sformatf("v%0d_latency", v), n, vecs[v].lat);
      check($sformatf("v%0d_single_pulse", v), np, 1);
      if (vecs[v].kind == 0) check($sformatf("v%0d_ins_addr", v), int'(a), int'(vecs[v].addr));
      if (vecs[v].kind <= 1) check($sformatf("v%0d_ins_data", v), int'(d), int'(vecs[v].floor));
      @(negedge clk);
      check($sformatf("v%0d_ready_after", v), int'(req_ready), 1);
      check($sformatf("v%0d_busy_after", v), int'(busy), 0);
      check_q($sformatf("v%0d_queue", v), vecs[v].q_out);
    end

    // head pop during SCAN: [3,7,9], c=2 up, req 8 -> rescan of [7,9], fit at 1
    load_queue(64'h973);
    send_req(4'd8, 4'd2, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("scan_shift_no_early_pulse",
            int'(ins_fit) + int'(ins_append) + int'(dup_drop) + int'(full_drop), 0);
    end
    queue_shift = 1'b1;
    #1;
    check("scan_shift_no_pulse_in_shift", int'(ins_fit) + int'(ins_append), 0);
    @(negedge clk);
    queue_shift = 1'b0;
    wait_pulse(n, kind, np, a, d);
    check("scan_shift_kind", kind, 0);
    check("scan_shift_latency", n, 3);
    check("scan_shift_addr", int'(a), 1);
    check("scan_shift_data", int'(d), 8);
    @(negedge clk);
    check_q("scan_shift_queue", 64'h987);

    // head pop on the issue cycle: [3,7], c=2 up, req 5 -> masked, then fit at 0
    load_queue(64'h73);
    send_req(4'd5, 4'd2, 1'b1);
    for (int i = 1; i <= 3; i++) @(negedge clk);
    @(negedge clk);
    check("issue_shift_fit_ready", int'(ins_fit), 1);
    queue_shift = 1'b1;
    #1;
    check("issue_shift_fit_masked", int'(ins_fit), 0);
    check("issue_shift_append_masked", int'(ins_append), 0);
    @(negedge clk);
    queue_shift = 1'b0;
    wait_pulse(n, kind, np, a, d);
    check("issue_shift_kind", kind, 0);
    check("issue_shift_latency", n, 2);
    check("issue_shift_addr", int'(a), 0);
    @(negedge clk);
    check_q("issue_shift_queue", 64'h75);

    // clear in the middle of a scan
    load_queue(64'h973);
    send_req(4'd8, 4'd2, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before_clear", int'(busy), 1);
    clear = 1'b1;
    #1;
    check("clr_req_ready", int'(req_ready), 1);
    check("clr_busy", int'(busy), 0);
    check("clr_pulses", int'(ins_fit) + int'(ins_append) + int'(dup_drop) + int'(full_drop), 0);
    check("clr_ins_addr", int'(ins_addr), 0);
    check("clr_rd_addr", int'(rd_addr), 0);
    @(negedge clk);
    clear = 1'b0;
    np = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      np += int'(ins_fit) + int'(ins_append) + int'(dup_drop) + int'(full_drop);
    end
    check("clr_no_pulse_after", np, 0);
    check_q("clr_queue", 64'h973);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/request_inserter.md
Name: request_inserter

Overview:
- Upstream feeder of the 16x4 floor-request queue RAM. Queue holds floors 1..15; value 0 means an empty slot. Entries are packed from index 0; index 0 is the head.
- Accepts one floor request at a time and scans the queue through the RAM's asynchronous secondary read port.
- Finds the sweep-ordered insertion point for the current position and direction. Issues one fit (insert-at) or weT (append) command, or drops the request as duplicate, invalid or queue-full.

Parameters:
DEPTH, 16, queue entries; scan index range 0..DEPTH-1
FW, 4, floor/data width

Ports:
clk  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
req_valid  in  1  new floor request present
req_floor  in  4  requested floor
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready on a clk edge
current_floor  in  4  car position, sampled at accept
going_up  in  1  car direction, sampled at accept
queue_shift  in  1  head pop by the downstream consumer, same cycle as the RAM shift
rd_addr  out  4  to RAM addrSecundario
rd_data  in  4  from RAM saidaSecundaria, combinational read of ram[rd_addr]
ins_addr  out  4  insertion index, to RAM addrSecundario while ins_fit is high
ins_data  out  4  floor to write, to RAM data
ins_fit  out  1  one-cycle insert-at-index pulse, to RAM fit
ins_append  out  1  one-cycle append pulse, to RAM weT
dup_drop  out  1  one-cycle pulse: duplicate, or floor 0 rejected
full_drop  out  1  one-cycle pulse: queue full, request dropped
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, clear=1): state IDLE. Outputs: req_ready=1, busy=0, ins_fit=0, ins_append=0, dup_drop=0, full_drop=0, ins_addr=0, ins_data=0, rd_addr=0. Latched floor, current floor, direction and scan index all go to 0. A clear mid-operation aborts the operation with no write pulse.
- Address muxing: rd_addr and ins_addr share the RAM addrSecundario input. The top level muxes them: ins_addr when ins_fit is high, rd_addr otherwise.
- Sweep key, 5-bit unsigned, f = floor, c = latched current floor:
  - going_up, f>=c: key = f-c.
  - going_up, f<c: key = 15+(c-f).
  - going down, f<=c: key = c-f.
  - going down, f>c: key = 15+(f-c).
- States:
  - IDLE:
    - On accept, latch req_floor, current_floor and going_up.
    - If req_floor==0: dup_drop pulses next cycle, stay IDLE.
    - Otherwise go to CHKF.
  - CHKF: rd_addr=15.
    - If rd_data!=0: full_drop pulse, go to IDLE.
    - Otherwise set idx=0 and go to SCAN.
  - SCAN: rd_addr=idx, one entry per cycle.
    - rd_data==floor: dup_drop, go to IDLE.
    - rd_data==0: go to ISSUE in mode append.
    - key(rd_data) > key(floor): go to ISSUE in mode fit at idx.
    - Otherwise idx+1. idx never passes 14, because CHKF guaranteed ram[15]==0.
  - ISSUE: registered one-cycle pulse. ins_fit (ins_addr=idx) or ins_append, with ins_data=floor. Then go to IDLE.
- Ties: equal keys with different floors cannot occur. Equal floors are caught as duplicates.
- queue_shift high in CHKF or SCAN: restart at CHKF, with idx and the latched request kept.
- queue_shift high in the cycle ISSUE would pulse: suppress the pulse and restart at CHKF. A write is never issued in a shift cycle.
- Latency:
  - Accept to write pulse = 3+k cycles, with k = index of the decision entry.
  - Drop paths: floor 0 = 1 cycle, full = 2 cycles.
  - req_ready returns the cycle after the pulse.
- current_floor and going_up changes after accept are ignored until the next request.

Test Plan:
1. Queue [3,7,0..], c=2, up, req 5 -> keys 1,5 vs 3; ins_fit with ins_addr=1, ins_data=5, 4 cycles after accept; queue becomes [3,5,7].
2. Same queue, req 7 -> dup_drop pulse at SCAN idx1; no ins_fit or ins_append pulse; req_ready back high.
3. Queue [3,7], c=2, up, req 1 (key 16) -> ins_append with ins_data=1 at idx2; queue [3,7,1].
4. Queue [4,12], c=9, down, req 6 (key 3 vs 5,18) -> ins_fit with ins_addr=0; queue [6,4,12].
5. ram[15]=8, req 2 -> full_drop 2 cycles after accept, no write; req_floor=0 -> dup_drop after 1 cycle.
6. queue_shift asserted during SCAN, and separately on the ISSUE cycle -> no pulse in the shift cycle, rescan, correct index. clear mid-SCAN -> all outputs 0, req_ready=1.
